// File: rtl/clint_timer.sv
// clint_timer: machine-level core-local interruptor (msip, mtime, mtimecmp) for a single hart
// Ports:
//   clk_in, rst_n                      clock (posedge) and synchronous active-low reset
//   bus_req, bus_we, bus_addr, bus_wdata  one request per cycle, always accepted
//   bus_ack, bus_rdata, bus_err        registered response, one cycle after each request
//   timer_irq                          level, mtime >= mtimecmp (registered)
//   sw_irq                             level, registered copy of msip
module clint_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        timer_irq,
  output logic        sw_irq
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] r_pcnt;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_msip;
  logic          w_tick;
  logic          w_sel_msip;
  logic          w_sel_cmp_lo;
  logic          w_sel_cmp_hi;
  logic          w_sel_mt_lo;
  logic          w_sel_mt_hi;
  logic          w_err;
  logic          w_wr;
  logic [31:0]   w_rdata;
  assign w_tick       = r_pcnt == CW'(PRESCALE - 1);
  assign w_sel_msip   = bus_addr == 16'h0000;
  assign w_sel_cmp_lo = bus_addr == 16'h4000;
  assign w_sel_cmp_hi = bus_addr == 16'h4004;
  assign w_sel_mt_lo  = bus_addr == 16'hBFF8;
  assign w_sel_mt_hi  = bus_addr == 16'hBFFC;
  // every mapped offset is word aligned, so a misaligned address simply matches nothing
  assign w_err = ~(w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi | w_sel_mt_lo | w_sel_mt_hi);
  assign w_wr  = bus_req & bus_we & ~w_err;
  always_comb
    w_rdata = w_sel_msip   ? {31'b0, r_msip}     :
              w_sel_cmp_lo ? r_mtimecmp[31:0]    :
              w_sel_cmp_hi ? r_mtimecmp[63:32]   :
              w_sel_mt_lo  ? r_mtime[31:0]       :
              w_sel_mt_hi  ? r_mtime[63:32]      : 32'h0;
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_pcnt     <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      bus_ack    <= 1'b0;
      bus_err    <= 1'b0;
      bus_rdata  <= '0;
      timer_irq  <= 1'b0;
      sw_irq     <= 1'b0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + CW'(1);
      // a write to either mtime half wins over the tick; the tick is lost, not deferred
      if (w_wr & w_sel_mt_lo)
        r_mtime[31:0] <= bus_wdata;
      else if (w_wr & w_sel_mt_hi)
        r_mtime[63:32] <= bus_wdata;
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
      if (w_wr & w_sel_cmp_lo)
        r_mtimecmp[31:0] <= bus_wdata;
      if (w_wr & w_sel_cmp_hi)
        r_mtimecmp[63:32] <= bus_wdata;
      if (w_wr & w_sel_msip)
        r_msip <= bus_wdata[0];
      bus_ack   <= bus_req;
      bus_err   <= bus_req & w_err;
      bus_rdata <= (bus_req & ~bus_we) ? w_rdata : 32'h0;
      timer_irq <= r_mtime >= r_mtimecmp;
      sw_irq    <= r_msip;
    end
  end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: PRESCALE=1 and PRESCALE=4 instances on a shared bus against a cycle model
module tb_clint_timer;
  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [15:0] bus_addr = 16'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        d_ack[2];
  logic        d_err[2];
  logic        d_tirq[2];
  logic        d_sirq[2];
  logic [31:0] d_rd[2];
  int checks = 0;
  int errors = 0;
  always #5 clk_in = ~clk_in;
  clint_timer #(.PRESCALE(1)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(d_ack[0]), .bus_rdata(d_rd[0]),
    .bus_err(d_err[0]), .timer_irq(d_tirq[0]), .sw_irq(d_sirq[0])
  );
  clint_timer #(.PRESCALE(4)) dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(d_ack[1]), .bus_rdata(d_rd[1]),
    .bus_err(d_err[1]), .timer_irq(d_tirq[1]), .sw_irq(d_sirq[1])
  );
  logic [63:0] m_time[2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  int unsigned m_cyc[2];
  logic        e_ack[2];
  logic        e_err[2];
  logic        e_tirq[2];
  logic        e_sirq[2];
  logic [31:0] e_rd[2];
  function automatic int region(logic [15:0] a);
    case (a)
      16'h0000: return 0;
      16'h4000: return 1;
      16'h4004: return 2;
      16'hBFF8: return 3;
      16'hBFFC: return 4;
      default:  return 5;
    endcase
  endfunction
  function automatic logic [31:0] regval(int k, int r);
    case (r)
      0: return {31'b0, m_msip[k]};
      1: return m_cmp[k][31:0];
      2: return m_cmp[k][63:32];
      3: return m_time[k][31:0];
      4: return m_time[k][63:32];
      default: return 32'h0;
    endcase
  endfunction
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int unsigned P = g == 0 ? 1 : 4;
    always @(posedge clk_in) begin
      if (!rst_n) begin
        m_time[g] <= 64'h0;
        m_cmp[g]  <= '1;
        m_msip[g] <= 1'b0;
        m_cyc[g]  <= 0;
        e_ack[g]  <= 1'b0;
        e_err[g]  <= 1'b0;
        e_tirq[g] <= 1'b0;
        e_sirq[g] <= 1'b0;
        e_rd[g]   <= 32'h0;
      end else begin
        m_cyc[g]  <= m_cyc[g] + 1;
        e_ack[g]  <= bus_req;
        e_err[g]  <= bus_req && region(bus_addr) == 5;
        e_rd[g]   <= (bus_req && !bus_we) ? regval(g, region(bus_addr)) : 32'h0;
        e_tirq[g] <= m_time[g] >= m_cmp[g];
        e_sirq[g] <= m_msip[g];
        if (bus_req && bus_we && region(bus_addr) == 3)
          m_time[g] <= {m_time[g][63:32], bus_wdata};
        else if (bus_req && bus_we && region(bus_addr) == 4)
          m_time[g] <= {bus_wdata, m_time[g][31:0]};
        else if (m_cyc[g] % P == P - 1)
          m_time[g] <= m_time[g] + 64'd1;
        if (bus_req && bus_we && region(bus_addr) == 1)
          m_cmp[g] <= {m_cmp[g][63:32], bus_wdata};
        if (bus_req && bus_we && region(bus_addr) == 2)
          m_cmp[g] <= {bus_wdata, m_cmp[g][31:0]};
        if (bus_req && bus_we && region(bus_addr) == 0)
          m_msip[g] <= bus_wdata[0];
      end
    end
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk_in);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ack[%0d]", k), 64'(d_ack[k]), 64'(e_ack[k]));
      chk($sformatf("err[%0d]", k), 64'(d_err[k]), 64'(e_err[k]));
      chk($sformatf("rdata[%0d]", k), 64'(d_rd[k]), 64'(e_rd[k]));
      chk($sformatf("timer_irq[%0d]", k), 64'(d_tirq[k]), 64'(e_tirq[k]));
      chk($sformatf("sw_irq[%0d]", k), 64'(d_sirq[k]), 64'(e_sirq[k]));
    end
  endtask
  task automatic req(logic we, logic [15:0] a, logic [31:0] d);
    bus_req = 1'b1;
    bus_we = we;
    bus_addr = a;
    bus_wdata = d;
    cyc();
    bus_req = 1'b0;
  endtask
  task automatic rdchk(string nm, logic [15:0] a, int k, logic [31:0] exp);
    req(1'b0, a, 32'h0);
    chk({nm, "_ack"}, 64'(d_ack[k]), 64'd1);
    chk({nm, "_err"}, 64'(d_err[k]), 64'd0);
    chk(nm, 64'(d_rd[k]), 64'(exp));
  endtask
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[14];
  initial begin
    int n;
    tbl[0]  = '{1'b1, 16'h4000, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 16'h4004, 32'h0000_00AB, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 16'h4000, 32'h0,         1'b0, 32'h1234_5678};
    tbl[3]  = '{1'b0, 16'h4004, 32'h0,         1'b0, 32'h0000_00AB};
    tbl[4]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 16'h0000, 32'h0,         1'b0, 32'h1};
    tbl[6]  = '{1'b0, 16'h0002, 32'h0,         1'b1, 32'h0};
    tbl[7]  = '{1'b0, 16'h1234, 32'h0,         1'b1, 32'h0};
    tbl[8]  = '{1'b1, 16'h8000, 32'h5,         1'b1, 32'h0};
    tbl[9]  = '{1'b1, 16'h4001, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b0, 16'h4000, 32'h0,         1'b0, 32'h1234_5678};
    tbl[11] = '{1'b1, 16'h0000, 32'h2,         1'b0, 32'h0};
    tbl[12] = '{1'b0, 16'h0000, 32'h0,         1'b0, 32'h0};
    tbl[13] = '{1'b0, 16'hBFFA, 32'h0,         1'b1, 32'h0};
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", 64'(d_ack[k]), 64'd0);
      chk("rst_rdata", 64'(d_rd[k]), 64'd0);
      chk("rst_tirq", 64'(d_tirq[k]), 64'd0);
      chk("rst_sirq", 64'(d_sirq[k]), 64'd0);
    end
    rst_n = 1'b1;
    repeat (10) cyc();
    req(1'b0, 16'hBFF8, 32'h0);
    chk("mtime_after_10", 64'(d_rd[0] >= 9 && d_rd[0] <= 11), 64'd1);
    chk("mtime_after_10_ack", 64'(d_ack[0]), 64'd1);
    chk("mtime_after_10_err", 64'(d_err[0]), 64'd0);
    req(1'b1, 16'hBFF8, 32'h0);
    req(1'b1, 16'h4004, 32'hFFFF_FFFF);
    req(1'b1, 16'h4000, 32'd20);
    req(1'b1, 16'h4004, 32'h0);
    n = 0;
    while (n < 40 && !d_tirq[0]) begin
      cyc();
      n++;
    end
    chk("tirq_rise_in_budget", 64'(d_tirq[0]), 64'd1);
    req(1'b1, 16'h4000, 32'd1000);
    cyc();
    chk("tirq_fall", 64'(d_tirq[0]), 64'd0);
    req(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    req(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    cyc();
    chk("tirq_at_max", 64'(d_tirq[0]), 64'd1);
    rdchk("mtime_wrap_lo", 16'hBFF8, 0, 32'h0);
    chk("tirq_after_wrap", 64'(d_tirq[0]), 64'd0);
    rdchk("mtime_wrap_hi", 16'hBFFC, 0, 32'h0);
    req(1'b1, 16'h0000, 32'hFFFF_FFFF);
    cyc();
    chk("sw_irq_set", 64'(d_sirq[0]), 64'd1);
    rdchk("msip_read", 16'h0000, 0, 32'h1);
    req(1'b1, 16'h0000, 32'h0);
    cyc();
    chk("sw_irq_clr", 64'(d_sirq[0]), 64'd0);
    for (int i = 0; i < 14; i++) begin
      bus_req = 1'b1;
      bus_we = tbl[i].we;
      bus_addr = tbl[i].addr;
      bus_wdata = tbl[i].wdata;
      cyc();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_ack", i), 64'(d_ack[k]), 64'd1);
        chk($sformatf("tbl%0d_err", i), 64'(d_err[k]), 64'(tbl[i].err));
        chk($sformatf("tbl%0d_rdata", i), 64'(d_rd[k]), 64'(tbl[i].rdata));
      end
    end
    bus_req = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    n = 0;
    while (n < 8 && m_cyc[1] % 4 != 2) begin
      cyc();
      n++;
    end
    req(1'b1, 16'hBFF8, 32'd100);
    req(1'b1, 16'hBFFC, 32'h0);
    rdchk("pre4_tick_dropped", 16'hBFF8, 1, 32'd100);
    repeat (3) cyc();
    rdchk("pre4_next_tick", 16'hBFF8, 1, 32'd101);
    bus_req = 1'b1;
    bus_we = 1'b0;
    bus_addr = 16'h4000;
    rst_n = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_mid_read_ack", 64'(d_ack[k]), 64'd0);
      chk("rst_mid_read_rdata", 64'(d_rd[k]), 64'd0);
    end
    bus_req = 1'b0;
    rst_n = 1'b1;
    rdchk("cmp_lo_after_rst", 16'h4000, 0, 32'hFFFF_FFFF);
    rdchk("mtime_hi_after_rst", 16'hBFFC, 1, 32'h0);
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      bus_req = $urandom_range(0, 3) != 0;
      bus_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: bus_addr = 16'h0000;
        1: bus_addr = 16'h4000;
        2: bus_addr = 16'h4004;
        3: bus_addr = 16'hBFF8;
        4: bus_addr = 16'hBFFC;
        default: bus_addr = 16'($urandom);
      endcase
      bus_wdata = $urandom_range(0, 1) != 0 ? $urandom : $urandom_range(0, 40);
      cyc();
    end
    bus_req = 1'b0;
    rst_n = 1'b1;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
